// File: rtl/gemm_pkg.sv
// Shared types and widths for the GEMM MAC sequencer.
package gemm_pkg;

  localparam int MAC_IN_W  = 8;
  localparam int MAC_ACC_W = 19;
  localparam int MAX_K_DIM = 15;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CAPTURE,
    FLUSH,
    DONE
  } seq_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_mac_sequencer_if.sv
// Result stream from the sequencer to the C sink (valid/ready).
interface gemm_mac_sequencer_if
  import gemm_pkg::*;
#(
  parameter int C_AW = 4
);
  logic                        c_valid;
  logic                        c_ready;
  logic [C_AW-1:0]             c_addr;
  logic signed [MAC_ACC_W-1:0] c_data;

  modport master (output c_valid, output c_addr, output c_data, input c_ready);
  modport slave  (input c_valid, input c_addr, input c_data, output c_ready);
endinterface

// File: rtl/gemm_addr_gen.sv
// i/j/k loop counters and the row-major A/B/C address arithmetic.
module gemm_addr_gen
  import gemm_pkg::*;
#(
  parameter int M_DIM = 4,
  parameter int N_DIM = 4,
  parameter int K_DIM = 8,
  parameter int A_AW  = 5,
  parameter int B_AW  = 5,
  parameter int C_AW  = 4
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            k_step,
  input  logic            elem_step,
  output logic            k_zero,
  output logic            k_last,
  output logic            elem_last,
  output logic [A_AW-1:0] a_addr,
  output logic [B_AW-1:0] b_addr,
  output logic [C_AW-1:0] c_addr
);

  localparam int IW = cnt_w(M_DIM);
  localparam int JW = cnt_w(N_DIM);
  localparam int KW = cnt_w(K_DIM);

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic          i_last;
  logic          j_last;

  assign k_zero    = (k == '0);
  assign k_last    = (k == KW'(K_DIM - 1));
  assign i_last    = (i == IW'(M_DIM - 1));
  assign j_last    = (j == JW'(N_DIM - 1));
  assign elem_last = i_last && j_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (k_step) k <= k_last ? '0 : k + KW'(1);
      // j is the inner loop so results come out row-major
      if (elem_step) begin
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + IW'(1);
        end else begin
          j <= j + JW'(1);
        end
      end
    end
  end

  assign a_addr = A_AW'(32'(i) * K_DIM + 32'(k));
  assign b_addr = B_AW'(32'(k) * N_DIM + 32'(j));
  assign c_addr = C_AW'(32'(i) * N_DIM + 32'(j));

endmodule

// File: rtl/gemm_mac_sequencer.sv
// Drives a single signed MAC through C = A x B; states: IDLE wait start | ISSUE read k | DRAIN last pair in MAC
// | CAPTURE latch result | FLUSH wait final handshake | DONE one-cycle pulse.
module gemm_mac_sequencer
  import gemm_pkg::*;
#(
  parameter int M_DIM = 4,
  parameter int N_DIM = 4,
  parameter int K_DIM = 8,
  parameter int A_AW  = $clog2(M_DIM * K_DIM),
  parameter int B_AW  = $clog2(K_DIM * N_DIM),
  parameter int C_AW  = $clog2(M_DIM * N_DIM)
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        a_rd_en,
  output logic [A_AW-1:0]             a_addr,
  input  logic signed [MAC_IN_W-1:0]  a_data,
  output logic                        b_rd_en,
  output logic [B_AW-1:0]             b_addr,
  input  logic signed [MAC_IN_W-1:0]  b_data,
  output logic signed [MAC_IN_W-1:0]  mac_inA,
  output logic signed [MAC_IN_W-1:0]  mac_inB,
  output logic                        mac_clear,
  output logic                        mac_write,
  input  logic signed [MAC_ACC_W-1:0] mac_out,
  gemm_mac_sequencer_if.master        c_if
);

  if (K_DIM > MAX_K_DIM) begin : g_k_check
    $error("gemm_mac_sequencer: K_DIM above 15 can overflow the 19-bit accumulator");
  end

  seq_state_t state, state_nxt;

  logic                        rd_en;
  logic                        load;
  logic                        elem_step;
  logic                        k_zero;
  logic                        k_last;
  logic                        elem_last;
  logic [C_AW-1:0]             c_addr_cur;
  logic                        rd_vld_d;
  logic                        k0_d;
  logic                        c_valid_q;
  logic [C_AW-1:0]             c_addr_q;
  logic signed [MAC_ACC_W-1:0] c_data_q;

  gemm_addr_gen #(
    .M_DIM(M_DIM), .N_DIM(N_DIM), .K_DIM(K_DIM),
    .A_AW(A_AW), .B_AW(B_AW), .C_AW(C_AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .k_step    (rd_en),
    .elem_step (elem_step),
    .k_zero    (k_zero),
    .k_last    (k_last),
    .elem_last (elem_last),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .c_addr    (c_addr_cur)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    load      = 1'b0;
    elem_step = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (k_last) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = CAPTURE;
      CAPTURE: begin
        // a blocked output register stalls here; the MAC is already holding
        if (!c_valid_q || c_if.c_ready) begin
          load      = 1'b1;
          elem_step = 1'b1;
          state_nxt = elem_last ? FLUSH : ISSUE;
        end
      end
      FLUSH: begin
        if (c_valid_q && c_if.c_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_d <= 1'b0;
      k0_d     <= 1'b0;
    end else begin
      rd_vld_d <= rd_en;
      k0_d     <= k_zero;
    end
  end

  assign a_rd_en   = rd_en;
  assign b_rd_en   = rd_en;
  assign mac_inA   = a_data;
  assign mac_inB   = b_data;
  assign mac_clear = rd_vld_d & k0_d;
  assign mac_write = ~rd_vld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_addr_q  <= '0;
      c_data_q  <= '0;
    end else if (load) begin
      c_valid_q <= 1'b1;
      c_addr_q  <= c_addr_cur;
      c_data_q  <= mac_out;
    end else if (c_valid_q && c_if.c_ready) begin
      c_valid_q <= 1'b0;
    end
  end

  assign c_if.c_valid = c_valid_q;
  assign c_if.c_addr  = c_addr_q;
  assign c_if.c_data  = c_data_q;

endmodule

// File: tb/tb_gemm_mac_sequencer.sv
// Scoreboard bench: 1-latency RAMs and a real MAC around the sequencer, results checked against a plain GEMM model.
module tb_gemm_mac_sequencer;
  import gemm_pkg::*;

  localparam int M = 2, N = 2, K = 3, K2 = 15;
  localparam int AAW = $clog2(M * K), BAW = $clog2(K * N), CAW = $clog2(M * N);
  localparam int AAW2 = $clog2(M * K2), BAW2 = $clog2(K2 * N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- main instance: M=N=2, K=3 ----------------
  logic rst, start, busy, done, a_rd_en, b_rd_en, mac_clear, mac_write;
  logic [AAW-1:0] a_addr;
  logic [BAW-1:0] b_addr;
  logic signed [7:0] a_data = '0, b_data = '0, mac_ina, mac_inb;
  logic signed [18:0] mac_out = '0;
  logic signed [7:0] a_mem [M*K];
  logic signed [7:0] b_mem [K*N];

  gemm_mac_sequencer_if #(.C_AW(CAW)) c_if();

  gemm_mac_sequencer #(.M_DIM(M), .N_DIM(N), .K_DIM(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_data(a_data),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
    .mac_inA(mac_ina), .mac_inB(mac_inb), .mac_clear(mac_clear), .mac_write(mac_write),
    .mac_out(mac_out), .c_if(c_if)
  );

  always @(posedge clk) begin
    if (a_rd_en) a_data <= a_mem[a_addr];
    if (b_rd_en) b_data <= b_mem[b_addr];
  end

  always @(posedge clk) begin
    if (!mac_write) begin
      if (mac_clear) mac_out <= (mac_ina == 0) ? '0 : 19'(mac_ina) * 19'(mac_inb);
      else if (mac_ina != 0) mac_out <= mac_out + 19'(mac_ina) * 19'(mac_inb);
    end
  end

  typedef struct {int addr; int data;} exp_t;
  exp_t sb[$];
  int acc_cyc[$];
  int last_acc = -100, done_cnt = 0, stall_run = 0;
  logic pv = 1'b0, pr = 1'b0;
  int paddr = 0, pdata = 0;
  bit hold = 1'b0, rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!hold) c_if.c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
      stall_run = 0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", c_if.c_valid, 1);
        check("hold_addr", c_if.c_addr, paddr);
        check("hold_data", c_if.c_data, pdata);
      end
      if (c_if.c_valid && !c_if.c_ready) stall_run++;
      else stall_run = 0;
      if (stall_run >= K + 2) begin
        check("stall_rd_en", a_rd_en, 0);
        check("stall_mac_write", mac_write, 1);
      end
      if (c_if.c_valid && c_if.c_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got addr %0d data %0d expected no result", c_if.c_addr, c_if.c_data);
        end else begin
          e = sb.pop_front();
          check("c_addr", c_if.c_addr, e.addr);
          check("c_data", c_if.c_data, e.data);
        end
        last_acc = cyc;
        acc_cyc.push_back(cyc);
      end
      if (done) begin
        check("done_after_accept", cyc - last_acc, 1);
        check("done_sb_empty", sb.size(), 0);
        check("done_busy", busy, 1);
        done_cnt++;
      end
      pv = c_if.c_valid;
      pr = c_if.c_ready;
      paddr = int'(c_if.c_addr);
      pdata = int'(c_if.c_data);
    end
  end

  task automatic fill(input int kind);
    if (kind == 0) begin
      a_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6};
      b_mem = '{8'sd1, 8'sd0, 8'sd0, 8'sd1, 8'sd1, 8'sd1};
    end else begin
      for (int x = 0; x < M * K; x++) a_mem[x] = 8'($urandom_range(0, 255));
      for (int x = 0; x < K * N; x++) b_mem[x] = 8'($urandom_range(0, 255));
      if (kind == 2) for (int x = 0; x < K; x++) a_mem[x] = '0;
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < K; k++) s += int'(a_mem[i*K + k]) * int'(b_mem[k*N + j]);
        sb.push_back('{i*N + j, s});
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_a_rd_en"}, a_rd_en, 0);
    check({tag, "_b_rd_en"}, b_rd_en, 0);
    check({tag, "_a_addr"}, a_addr, 0);
    check({tag, "_b_addr"}, b_addr, 0);
    check({tag, "_mac_clear"}, mac_clear, 0);
    check({tag, "_mac_write"}, mac_write, 1);
    check({tag, "_c_valid"}, c_if.c_valid, 0);
    check({tag, "_c_addr"}, c_if.c_addr, 0);
    check({tag, "_c_data"}, c_if.c_data, 0);
  endtask

  task automatic run_gemm(input int kind, input bit stall, input bit mid_start, input bit period_chk);
    int d0;
    d0 = done_cnt;
    acc_cyc.delete();
    fill(kind);
    if (stall) begin
      hold = 1'b1;
      c_if.c_ready = 1'b0;
    end
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    if (stall) begin
      for (int t = 0; t < 50 && !c_if.c_valid; t++) @(negedge clk);
      check("stall_first_valid", c_if.c_valid, 1);
      repeat (10) @(posedge clk);
      #1 c_if.c_ready = 1'b1;
      hold = 1'b0;
    end
    if (mid_start) begin
      repeat (7) @(posedge clk);
      pulse_start();
    end
    for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("idle_after_done", busy, 0);
    check("all_results_seen", sb.size(), 0);
    if (period_chk) begin
      check("accept_count", acc_cyc.size(), M * N);
      for (int x = 1; x < acc_cyc.size(); x++)
        check("element_period", acc_cyc[x] - acc_cyc[x-1], K + 2);
    end
    sb.delete();
  endtask

  // ---------------- K=15 instance: overflow bound ----------------
  logic rst2, start2, busy2, done2, a2_rd_en, b2_rd_en, mac2_clear, mac2_write;
  logic [AAW2-1:0] a2_addr;
  logic [BAW2-1:0] b2_addr;
  logic signed [7:0] a2_data = '0, b2_data = '0, mac2_ina, mac2_inb;
  logic signed [18:0] mac2_out = '0;
  int exp15 = 0, addr15 = 0, done2_cnt = 0;

  gemm_mac_sequencer_if #(.C_AW(CAW)) c2_if();

  gemm_mac_sequencer #(.M_DIM(M), .N_DIM(N), .K_DIM(K2)) dut15 (
    .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
    .a_rd_en(a2_rd_en), .a_addr(a2_addr), .a_data(a2_data),
    .b_rd_en(b2_rd_en), .b_addr(b2_addr), .b_data(b2_data),
    .mac_inA(mac2_ina), .mac_inB(mac2_inb), .mac_clear(mac2_clear), .mac_write(mac2_write),
    .mac_out(mac2_out), .c_if(c2_if)
  );

  assign c2_if.c_ready = 1'b1;

  always @(posedge clk) begin
    if (a2_rd_en) a2_data <= -8'sd128;
    if (b2_rd_en) b2_data <= -8'sd128;
    if (!mac2_write) begin
      if (mac2_clear) mac2_out <= 19'(mac2_ina) * 19'(mac2_inb);
      else mac2_out <= mac2_out + 19'(mac2_ina) * 19'(mac2_inb);
    end
  end

  always @(negedge clk) begin
    if (!rst2) begin
      if (c2_if.c_valid && c2_if.c_ready) begin
        check("k15_c_data", c2_if.c_data, exp15);
        check("k15_c_addr", c2_if.c_addr, addr15);
        addr15++;
      end
      if (done2) done2_cnt++;
    end
  end

  // ---------------- sequence ----------------
  initial begin
    int d0;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    c_if.c_ready = 1'b1;
    for (int k = 0; k < K2; k++) exp15 += (-128) * (-128);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    run_gemm(0, 1'b0, 1'b0, 1'b1);
    run_gemm(2, 1'b0, 1'b0, 1'b1);
    run_gemm(1, 1'b1, 1'b0, 1'b0);
    run_gemm(1, 1'b0, 1'b1, 1'b1);

    // reset while the second element is reading k=1
    d0 = done_cnt;
    fill(1);
    pulse_start();
    for (int t = 0; t < 100 && !(a_rd_en && a_addr == AAW'(1) && b_addr == BAW'(N + 1)); t++)
      @(negedge clk);
    check("rst_point_reached", a_rd_en && a_addr == AAW'(1) && b_addr == BAW'(N + 1), 1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_cnt - d0, 0);
    run_gemm(1, 1'b0, 1'b0, 1'b1);

    rand_ready = 1'b1;
    repeat (3) run_gemm(1, 1'b0, 1'b0, 1'b0);
    rand_ready = 1'b0;
    @(posedge clk);

    @(posedge clk); #1 rst2 = 1'b0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int t = 0; t < 300 && done2_cnt == 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("k15_result_count", addr15, M * N);
    check("k15_done_count", done2_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
